// File: rtl/sync_w2r_bin_if.sv
// ---------------------------------------------------------------------------
// sync_w2r_bin_if
//   Signal bundle between the write-pointer synchronizer and its read-domain
//   consumers (empty-flag and occupancy logic).
//
//   Parameter
//     ADDRSIZE   FIFO address width; pointers are ADDRSIZE+1 bits wide.
//                Must match the ADDRSIZE of the sync_w2r_bin instance.
//
//   Signals
//     wptr       Gray-coded write pointer, asynchronous to the read clock
//     err_clr    clears the sticky overrun flag (read-clock domain)
//     rq_wptr    synchronized Gray write pointer
//     rq_wbin    registered binary write pointer
//     rq_wdelta  positions advanced since the previous rq_wbin
//     rq_wupd    one-cycle strobe, high when rq_wdelta is nonzero
//     gray_err   sticky overrun flag
//
//   Modports
//     master     the side that supplies wptr/err_clr and consumes results
//     slave      the synchronizer itself
// ---------------------------------------------------------------------------
interface sync_w2r_bin_if #(
  parameter int ADDRSIZE = 6
);
  logic [ADDRSIZE:0] wptr;
  logic              err_clr;
  logic [ADDRSIZE:0] rq_wptr;
  logic [ADDRSIZE:0] rq_wbin;
  logic [ADDRSIZE:0] rq_wdelta;
  logic              rq_wupd;
  logic              gray_err;

  modport master (
    output wptr,
    output err_clr,
    input  rq_wptr,
    input  rq_wbin,
    input  rq_wdelta,
    input  rq_wupd,
    input  gray_err
  );

  modport slave (
    input  wptr,
    input  err_clr,
    output rq_wptr,
    output rq_wbin,
    output rq_wdelta,
    output rq_wupd,
    output gray_err
  );
endinterface

// File: rtl/sync_w2r_bin.sv
// ---------------------------------------------------------------------------
// sync_w2r_bin
//   Carries the Gray-coded FIFO write pointer into the read clock domain
//   through a flop chain, converts it to binary and registers it together
//   with the advance since the previous sample, an update strobe and an
//   optional sticky overrun flag.
//
//   Parameters
//     ADDRSIZE     FIFO address width (pointer width ADDRSIZE+1, depth
//                  2^ADDRSIZE)
//     SYNC_STAGES  number of synchronizer flops, 2..4
//
//   Ports
//     rclk         read-domain clock, the only clock of the block
//     rrst_n       synchronous active-low reset; clears every register
//     bus          sync_w2r_bin_if slave modport:
//                    wptr (in), err_clr (in), rq_wptr, rq_wbin,
//                    rq_wdelta, rq_wupd, gray_err (out)
//
//   Build option
//     SYNC_W2R_OVERRUN_CHECK_EN  when defined, a delta larger than the FIFO
//                  depth sets the sticky gray_err flag, cleared by err_clr
//                  (a set on the same edge wins). When undefined, gray_err
//                  is tied to 0 and err_clr is ignored.
//
//   Latency: wptr -> rq_wptr is SYNC_STAGES edges; wptr -> rq_wbin,
//   rq_wdelta, rq_wupd, gray_err is SYNC_STAGES+1 edges. All outputs are
//   registered.
// ---------------------------------------------------------------------------
module sync_w2r_bin #(
  parameter int ADDRSIZE    = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic           rclk,
  input  logic           rrst_n,
  sync_w2r_bin_if.slave  bus
);

  localparam int PW = ADDRSIZE + 1;
  // Largest legal advance between two samples: one full FIFO depth.
  localparam logic [PW-1:0] DEPTH = PW'(1) << ADDRSIZE;

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("sync_w2r_bin: SYNC_STAGES must be in 2..4");
    end
  endgenerate

  // Gray to binary: each binary bit is the XOR of all Gray bits at or
  // above it.
  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // -------------------------------------------------------------------------
  // Synchronizer chain: plain flop-to-flop, no logic between stages.
  // -------------------------------------------------------------------------
  logic [PW-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= bus.wptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign bus.rq_wptr = sync_q[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Conversion stage: binary pointer, advance and strobe load together.
  // -------------------------------------------------------------------------
  logic [PW-1:0] wbin_d,   wbin_q;
  logic [PW-1:0] wdelta_d, wdelta_q;
  logic          wupd_d,   wupd_q;

  always_comb begin
    wbin_d   = g2b(sync_q[SYNC_STAGES-1]);
    // Modular subtraction handles pointer wrap; the pointer never moves
    // backwards so the result is always a forward advance.
    wdelta_d = wbin_d - wbin_q;
    wupd_d   = (wbin_d != wbin_q);
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      wbin_q   <= '0;
      wdelta_q <= '0;
      wupd_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wdelta_q <= wdelta_d;
      wupd_q   <= wupd_d;
    end
  end

  assign bus.rq_wbin   = wbin_q;
  assign bus.rq_wdelta = wdelta_q;
  assign bus.rq_wupd   = wupd_q;

`ifdef SYNC_W2R_OVERRUN_CHECK_EN
  // -------------------------------------------------------------------------
  // Overrun flag: loads on the same edge as the delta it judges.
  // -------------------------------------------------------------------------
  logic ovr_d;
  logic gray_err_d, gray_err_q;

  always_comb begin
    ovr_d      = (wdelta_d > DEPTH);
    // Set takes priority over a simultaneous clear.
    gray_err_d = ovr_d | (gray_err_q & ~bus.err_clr);
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      gray_err_q <= 1'b0;
    end else begin
      gray_err_q <= gray_err_d;
    end
  end

  assign bus.gray_err = gray_err_q;
`else
  logic unused_err_clr;
  logic [PW-1:0] unused_depth;

  assign unused_err_clr = bus.err_clr;
  assign unused_depth   = DEPTH;
  assign bus.gray_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sync_w2r_bin.sv
module tb_sync_w2r_bin;

  localparam int A  = 6;
  localparam int S  = 2;
  localparam int PW = A + 1;

  logic rclk   = 1'b0;
  logic rrst_n = 1'b0;

  always #5 rclk = ~rclk;

  sync_w2r_bin_if #(.ADDRSIZE(A)) bus ();

  sync_w2r_bin #(.ADDRSIZE(A), .SYNC_STAGES(S)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (bus)
  );

  // Reference: the binary write pointer presented at each edge, newest
  // first. Outputs are this history delayed by the documented latency.
  logic [PW-1:0] h[$];
  logic [PW-1:0] e_delta;
  bit            err_m;
  int            n_cmp = 0;
  int            n_bad = 0;
  int            upd_cnt;

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One rclk edge with the given binary write pointer, err_clr and reset,
  // then compare every output against the reference.
  task automatic step(input logic [PW-1:0] b, input logic clr, input logic rst_n);
    bus.wptr    = to_gray(b);
    bus.err_clr = clr;
    rrst_n      = rst_n;
    @(posedge rclk);
    if (!rst_n) begin
      foreach (h[i]) h[i] = '0;
      err_m   = 1'b0;
      e_delta = '0;
    end else begin
      h.push_front(b);
      void'(h.pop_back());
      e_delta = h[S] - h[S+1];
`ifdef SYNC_W2R_OVERRUN_CHECK_EN
      if (e_delta > (1 << A)) err_m = 1'b1;
      else if (clr)           err_m = 1'b0;
`endif
    end
    #1;
    chk("rq_wptr",   bus.rq_wptr,   to_gray(h[S-1]));
    chk("rq_wbin",   bus.rq_wbin,   h[S]);
    chk("rq_wdelta", bus.rq_wdelta, e_delta);
    chk("rq_wupd",   bus.rq_wupd,   (e_delta != 0));
    chk("gray_err",  bus.gray_err,  err_m);
  endtask

  initial begin
    logic [PW-1:0] cur;
    logic [PW-1:0] nxt;
    int r;

    for (int i = 0; i < S + 2; i++) h.push_back('0);
    bus.wptr    = '0;
    bus.err_clr = 1'b0;

    // Reset held for three edges, then idle at 0.
    step(7'd0, 1'b0, 1'b0);
    step(7'd0, 1'b0, 1'b0);
    step(7'd0, 1'b0, 1'b0);
    chk("rst_wbin", bus.rq_wbin, 0);
    chk("rst_wupd", bus.rq_wupd, 0);
    step(7'd0, 1'b0, 1'b1);
    step(7'd0, 1'b0, 1'b1);
    chk("idle_wupd", bus.rq_wupd, 0);

    // Single increment 0 -> 1.
    step(7'd1, 1'b0, 1'b1);
    step(7'd1, 1'b0, 1'b1);
    chk("inc_wptr_2edges", bus.rq_wptr, 7'h01);
    step(7'd1, 1'b0, 1'b1);
    chk("inc_wbin", bus.rq_wbin, 1);
    chk("inc_delta", bus.rq_wdelta, 1);
    chk("inc_wupd", bus.rq_wupd, 1);
    step(7'd1, 1'b0, 1'b1);
    chk("inc_wupd_drop", bus.rq_wupd, 0);
    chk("inc_delta_zero", bus.rq_wdelta, 0);

    // Multi-step jump 1 -> 5 (Gray 0x07).
    step(7'd5, 1'b0, 1'b1);
    chk("jump_gray_in", bus.wptr, 7'h07);
    step(7'd5, 1'b0, 1'b1);
    step(7'd5, 1'b0, 1'b1);
    chk("jump_wbin", bus.rq_wbin, 5);
    chk("jump_delta", bus.rq_wdelta, 4);
    step(7'd5, 1'b0, 1'b1);
    chk("jump_one_pulse", bus.rq_wupd, 0);

    // Walk legally up to 127, then wrap to 0.
    for (int i = 0; i < 4; i++) step(7'd60, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(7'd120, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(7'd127, 1'b0, 1'b1);
    chk("wrap_gray_127", bus.rq_wptr, 7'h40);
    step(7'd0, 1'b0, 1'b1);
    step(7'd0, 1'b0, 1'b1);
    step(7'd0, 1'b0, 1'b1);
    chk("wrap_wbin", bus.rq_wbin, 0);
    chk("wrap_delta", bus.rq_wdelta, 1);
    chk("wrap_no_err", bus.gray_err, 0);
    step(7'd0, 1'b0, 1'b1);

    // Overrun 0 -> 65 (Gray 0x61).
    step(7'd65, 1'b0, 1'b1);
    chk("ovr_gray_in", bus.wptr, 7'h61);
    step(7'd65, 1'b0, 1'b1);
    step(7'd65, 1'b0, 1'b1);
    chk("ovr_delta", bus.rq_wdelta, 65);
`ifdef SYNC_W2R_OVERRUN_CHECK_EN
    chk("ovr_err_set", bus.gray_err, 1);
`else
    chk("ovr_err_off", bus.gray_err, 0);
`endif
    step(7'd65, 1'b0, 1'b1);
    step(7'd65, 1'b0, 1'b1);
`ifdef SYNC_W2R_OVERRUN_CHECK_EN
    chk("ovr_err_held", bus.gray_err, 1);
`endif
    step(7'd65, 1'b1, 1'b1);
    chk("ovr_err_clr", bus.gray_err, 0);
    step(7'd65, 1'b0, 1'b1);
    // 65 -> 2 is another advance of 65; clear on the same edge it lands.
    step(7'd2, 1'b0, 1'b1);
    step(7'd2, 1'b0, 1'b1);
    step(7'd2, 1'b1, 1'b1);
    chk("ovr2_delta", bus.rq_wdelta, 65);
`ifdef SYNC_W2R_OVERRUN_CHECK_EN
    chk("ovr_set_wins", bus.gray_err, 1);
`else
    chk("ovr_set_off", bus.gray_err, 0);
`endif
    step(7'd2, 1'b1, 1'b1);
    chk("ovr_err_clr2", bus.gray_err, 0);

    // Reset mid-operation while wptr keeps moving.
    for (int i = 0; i < 4; i++) step(7'd37, 1'b0, 1'b1);
    chk("mid_wbin37", bus.rq_wbin, 37);
    step(7'd38, 1'b0, 1'b1);
    step(7'd39, 1'b0, 1'b0);
    chk("mid_rst_wptr", bus.rq_wptr, 0);
    chk("mid_rst_wbin", bus.rq_wbin, 0);
    chk("mid_rst_delta", bus.rq_wdelta, 0);
    step(7'd40, 1'b0, 1'b1);
    step(7'd41, 1'b0, 1'b1);
    chk("mid_latency_hold", bus.rq_wbin, 0);
    step(7'd42, 1'b0, 1'b1);
    chk("mid_first_delta", bus.rq_wdelta, 40);
    for (int i = 0; i < 4; i++) step(7'd42, 1'b0, 1'b1);

    // Back-to-back single increments for eight cycles.
    upd_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      step(7'(42 + i), 1'b0, 1'b1);
      if (bus.rq_wupd === 1'b1) upd_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      step(7'd50, 1'b0, 1'b1);
      if (bus.rq_wupd === 1'b1) upd_cnt++;
    end
    chk("b2b_pulses", upd_cnt, 8);
    chk("b2b_final_wbin", bus.rq_wbin, 50);

    // Randomized advances, occasional large jumps, clears and resets.
    cur = 7'd50;
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 19));
      if (r < 12)      nxt = cur + 7'($urandom_range(0, 2));
      else if (r < 18) nxt = cur + 7'($urandom_range(0, 64));
      else             nxt = cur + 7'($urandom_range(0, 127));
      if ($urandom_range(0, 59) == 0) begin
        step(nxt, 1'b0, 1'b0);
      end else begin
        step(nxt, ($urandom_range(0, 7) == 0), 1'b1);
      end
      cur = nxt;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_w2r_bin.md
# sync_w2r_bin

Parametrised write-to-read pointer synchronizer for the asynchronous FIFO. It carries the Gray-coded write pointer into the read clock domain through a configurable number of flop stages, then registers it as a binary pointer. Alongside the binary pointer it produces a per-cycle advance count (delta), an update strobe and an optional overrun check. It sits in the read-clock half of the FIFO and feeds empty-flag and read-side occupancy logic.

## Interface
- ADDRSIZE, 6: FIFO address width; pointers are ADDRSIZE+1 bits, depth 2^ADDRSIZE.
- SYNC_STAGES, 2: number of synchronizer flops; legal range 2..4.

- rclk  input  1  read-domain clock; sole clock of the block.
- rrst_n  input  1  reset, synchronous, active-low.
- wptr  input  ADDRSIZE+1  Gray-coded write pointer, asynchronous to rclk.
- err_clr  input  1  clears sticky gray_err; rclk domain.
- rq_wptr  output  ADDRSIZE+1  synchronized Gray write pointer (last sync stage).
- rq_wbin  output  ADDRSIZE+1  registered binary write pointer.
- rq_wdelta  output  ADDRSIZE+1  positions advanced since the previous rq_wbin.
- rq_wupd  output  1  single-cycle strobe; 1 when rq_wdelta != 0.
- gray_err  output  1  sticky overrun flag.

## Operation
- Sync chain: SYNC_STAGES registers. Stage 1 samples wptr. Each later stage samples the previous one. rq_wptr is the last stage. No logic is allowed between stages.
- Conversion stage: g2b(rq_wptr) is computed combinationally (bin[MSB]=gray[MSB]; bin[i]=bin[i+1]^gray[i]). Each rclk it is registered as follows:
  - rq_wbin <= g2b(rq_wptr).
  - rq_wdelta <= g2b(rq_wptr) - rq_wbin, modulo 2^(ADDRSIZE+1). This gives correct wrap-around.
  - rq_wupd <= (g2b(rq_wptr) != rq_wbin).
- Delta is unsigned. The write pointer never moves backwards, so any nonzero delta is an advance.
- Overrun check: a computed delta greater than 2^ADDRSIZE is illegal, because it exceeds the FIFO depth.
  - An illegal delta sets gray_err at the same edge rq_wdelta is loaded.
  - gray_err stays set until an edge with err_clr=1.
  - If set and clear occur on the same edge, set wins.
- The block has no FSM; behaviour is a pure pipeline plus one sticky bit.
- Reset (rrst_n=0 at an rclk edge):
  - Every sync stage, rq_wptr, rq_wbin, rq_wdelta, rq_wupd and gray_err go to 0.
  - Reset overrides all other activity, including mid-stream.
  - After release with wptr=0, rq_wupd stays 0.

## Timing
- wptr change to rq_wptr: SYNC_STAGES rclk edges.
- wptr change to rq_wbin, rq_wdelta, rq_wupd and gray_err: SYNC_STAGES+1 edges. These four outputs always update together.
- rq_wupd is high for exactly one cycle per observed change.
  - If rq_wptr changes on consecutive cycles, rq_wupd stays high on consecutive cycles.
  - Each of those cycles carries its own rq_wdelta.
- The sum of rq_wdelta over time equals the total write advance, modulo 2^(ADDRSIZE+1). Multi-increment jumps (wclk faster than rclk) are reported as one delta.
- When there is no change, rq_wdelta reads 0.
- All outputs are registered; none is combinational from an input.

## Configuration
- Macro: SYNC_W2R_OVERRUN_CHECK_EN.
- Defined: the overrun comparator and the sticky gray_err register are built, and err_clr is functional.
- Undefined: gray_err is tied to 0 and err_clr is ignored. Pointer, delta and strobe behaviour are identical in both builds.

## Test plan
All scenarios use ADDRSIZE=6 and SYNC_STAGES=2.
- Reset then single increment: hold rrst_n=0 for 3 edges, release, then drive wptr 0x00 -> 0x01.
  - rq_wptr=0x01 after 2 edges.
  - After 3 edges: rq_wbin=1, rq_wdelta=1, rq_wupd=1 for one cycle, then rq_wupd=0 and rq_wdelta=0.
- Multi-step jump: wptr 0x01 (bin 1) -> 0x07 (bin 5). Required: rq_wbin=5, rq_wdelta=4, one rq_wupd pulse.
- Wrap-around: settle wptr=0x40 (bin 127), then drive 0x00 (bin 0). Required: rq_wbin=0, rq_wdelta=1, gray_err stays 0.
- Overrun: from bin 0, drive wptr=0x61 (bin 65). Required:
  - rq_wdelta=65 and gray_err=1, held after wptr is steady.
  - Pulsing err_clr for one cycle clears gray_err.
  - With err_clr high on the same edge as a new illegal delta, gray_err stays 1.
  - In the build without SYNC_W2R_OVERRUN_CHECK_EN, gray_err stays 0 throughout.
- Reset mid-operation: with rq_wbin=37, assert rrst_n=0 for one edge while wptr keeps toggling. Required:
  - All outputs are 0 at that edge.
  - After release, outputs resume with the normal SYNC_STAGES+1 latency.
  - The first rq_wdelta equals the full pointer value measured from 0.
- Back-to-back updates: advance wptr by 1 on every rclk for 8 cycles. Required: rq_wupd stays high for 8 consecutive cycles with rq_wdelta=1 each cycle, and the final rq_wbin is the start value plus 8.
